reg_file_scoreboard: RTL and testbench

- Integer register file that sinks the write-back stage's commit (reg_write_w, rd_w, result_w) and sources the decode stage's operands.
- Integrates a load-pending scoreboard: a register is marked busy when a load issues in execute and cleared when write-back commits it.
- Raises stall_d for load-use hazards.
- Sits between the write-back stage and the decode stage / hazard unit.

---
 rtl/reg_file_scoreboard.sv | 107 ++++++++++
 tb/tb_reg_file_scoreboard.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Integer register file with load-pending scoreboard and load-use stall.
// Optional write-through forwarding: define RF_WRITE_BYPASS_EN.
module reg_file_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  output logic [XLEN-1:0]  rd1_d,
  output logic [XLEN-1:0]  rd2_d,
  input  logic             reg_write_w,
  input  logic [4:0]       rd_w,
  input  logic [XLEN-1:0]  result_w,
  input  logic             load_issue_e,
  input  logic [4:0]       rd_e,
  input  logic             flush,
  output logic             stall_d,
  output logic [NREGS-1:0] pending
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  logic wb_en;
  logic ld_en;
  logic wb_hit1;
  logic wb_hit2;
  logic pend1;
  logic pend2;

  assign wb_en   = reg_write_w && (rd_w != 5'd0);
  assign ld_en   = load_issue_e && (rd_e != 5'd0);
  assign wb_hit1 = wb_en && (rd_w == rs1_d);
  assign wb_hit2 = wb_en && (rd_w == rs2_d);

  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      regs_d[rd_w] = result_w;
    end
    regs_d[0] = '0;
  end

  // A newer load owns the register, so set is applied after clear/flush.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else if (wb_en) begin
      pend_d[rd_w] = 1'b0;
    end
    if (ld_en) begin
      pend_d[rd_e] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;
  assign pend1   = pend_q[rs1_d] && (rs1_d != 5'd0);
  assign pend2   = pend_q[rs2_d] && (rs2_d != 5'd0);

`ifdef RF_WRITE_BYPASS_EN
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1_d != 5'd0) begin
      rd1_d = wb_hit1 ? result_w : regs_q[rs1_d];
    end
    if (rs2_d != 5'd0) begin
      rd2_d = wb_hit2 ? result_w : regs_q[rs2_d];
    end
  end

  assign stall_d = (pend1 && !wb_hit1) || (pend2 && !wb_hit2);
`else
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1_d != 5'd0) begin
      rd1_d = regs_q[rs1_d];
    end
    if (rs2_d != 5'd0) begin
      rd2_d = regs_q[rs2_d];
    end
  end

  // Hold decode one cycle so it re-reads once the write has landed.
  assign stall_d = pend1 || pend2 || wb_hit1 || wb_hit2;
`endif

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard.
// Covers reset, write/read, x0, load-use, collision, flush and reset.
module tb_reg_file_scoreboard;

  logic        clk;
  logic        srst;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        load_issue_e;
  logic [4:0]  rd_e;
  logic        flush;
  logic        stall_d;
  logic [31:0] pending;

  int checks;
  int failures;

  reg_file_scoreboard #(
    .XLEN (32),
    .NREGS(32)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd1_d       (rd1_d),
    .rd2_d       (rd2_d),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .result_w    (result_w),
    .load_issue_e(load_issue_e),
    .rd_e        (rd_e),
    .flush       (flush),
    .stall_d     (stall_d),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_w  = 1'b0;
    rd_w         = 5'd0;
    result_w     = '0;
    load_issue_e = 1'b0;
    rd_e         = 5'd0;
    flush        = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    srst     = 1'b0;
    rs1_d    = 5'd0;
    rs2_d    = 5'd0;
    idle();

    repeat (2) tick();
    srst  = 1'b1;
    rs1_d = 5'd5;
    rs2_d = 5'd31;
    #1;
    check("rst_rd1", rd1_d, 32'h0);
    check("rst_rd2", rd2_d, 32'h0);
    check("rst_pend", pending, 32'h0);
    check("rst_stall", {31'd0, stall_d}, 32'h0);

    reg_write_w = 1'b1;
    rd_w        = 5'd3;
    result_w    = 32'hDEADBEEF;
    tick();
    rd_w        = 5'd0;
    result_w    = 32'h12345678;
    tick();
    idle();
    rs1_d = 5'd3;
    rs2_d = 5'd0;
    #1;
    check("wr_x3", rd1_d, 32'hDEADBEEF);
    check("wr_x0", rd2_d, 32'h0);

    rs1_d       = 5'd7;
    reg_write_w = 1'b1;
    rd_w        = 5'd7;
    result_w    = 32'hA5A5A5A5;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("byp_rd1", rd1_d, 32'hA5A5A5A5);
    check("byp_stall", {31'd0, stall_d}, 32'h0);
`else
    check("nobyp_rd1", rd1_d, 32'h0);
    check("nobyp_stall", {31'd0, stall_d}, 32'h1);
`endif
    tick();
    idle();
    #1;
    check("x7_after", rd1_d, 32'hA5A5A5A5);
    check("x7_stall", {31'd0, stall_d}, 32'h0);

    rs1_d        = 5'd0;
    load_issue_e = 1'b1;
    rd_e         = 5'd9;
    tick();
    idle();
    rs2_d = 5'd9;
    #1;
    check("lu_pend", pending, 32'h0000_0200);
    check("lu_stall", {31'd0, stall_d}, 32'h1);
    reg_write_w = 1'b1;
    rd_w        = 5'd9;
    result_w    = 32'h55;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("lu_wb_stall", {31'd0, stall_d}, 32'h0);
    check("lu_wb_rd2", rd2_d, 32'h55);
`else
    check("lu_wb_stall", {31'd0, stall_d}, 32'h1);
    check("lu_wb_rd2", rd2_d, 32'h0);
`endif
    tick();
    idle();
    #1;
    check("lu_clr_pend", pending, 32'h0);
    check("lu_clr_stall", {31'd0, stall_d}, 32'h0);
    check("lu_clr_rd2", rd2_d, 32'h55);

    rs2_d        = 5'd0;
    load_issue_e = 1'b1;
    rd_e         = 5'd4;
    tick();
    reg_write_w = 1'b1;
    rd_w        = 5'd4;
    result_w    = 32'h0000_0044;
    tick();
    idle();
    rs1_d = 5'd4;
    #1;
    check("col_pend", pending, 32'h0000_0010);
    check("col_rd1", rd1_d, 32'h0000_0044);
    check("col_stall", {31'd0, stall_d}, 32'h1);

    load_issue_e = 1'b1;
    rd_e         = 5'd0;
    tick();
    check("ld_x0", pending, 32'h0000_0010);
    rd_e = 5'd2;
    tick();
    rd_e = 5'd6;
    tick();
    check("pre_flush", pending, 32'h0000_0054);
    flush = 1'b1;
    rd_e  = 5'd8;
    tick();
    idle();
    check("flush_pend", pending, 32'h0000_0100);

    srst         = 1'b0;
    reg_write_w  = 1'b1;
    rd_w         = 5'd10;
    result_w     = 32'h1;
    load_issue_e = 1'b1;
    rd_e         = 5'd11;
    tick();
    srst = 1'b1;
    idle();
    #1;
    check("rst2_pend", pending, 32'h0);
    check("rst2_stall", {31'd0, stall_d}, 32'h0);
    for (int r = 1; r < 32; r += 3) begin
      rs1_d = 5'(r);
      rs2_d = 5'(r + 1);
      #1;
      check("rst2_rd1", rd1_d, 32'h0);
      check("rst2_rd2", rd2_d, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
